// File: rtl/sram_bus_arbiter_pkg.sv
// Shared types and widths for the SRAM-like bus arbiter that merges the IF and MEM masters.
package sram_bus_arbiter_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned SIZE_W = 2;

    typedef enum logic {
        ID_INST = 1'b0,
        ID_DATA = 1'b1
    } arb_id_e;

    // Request payload of one master; the granted one is forwarded to the memory port.
    typedef struct packed {
        logic              wr;
        logic [SIZE_W-1:0] size;
        logic [ADDR_W-1:0] addr;
        logic [STRB_W-1:0] wstrb;
        logic [DATA_W-1:0] wdata;
    } sram_req_t;

endpackage

// File: rtl/sram_bus_arbiter_id_fifo.sv
// In-order FIFO of issuer IDs for transactions accepted by the memory but not yet answered.
module arb_id_fifo #(
    parameter int unsigned DEPTH = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic push_i,
    input  logic din_i,
    input  logic pop_i,
    output logic full_o,
    output logic empty_o,
    output logic head_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [DEPTH-1:0] mem_q, mem_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din_i;
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        // Simultaneous push and pop leaves the occupancy unchanged.
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like port between the inst and data masters: data-first grant with an
// anti-starvation limit, handshake lock, and in-order routing of responses via an ID FIFO.
module sram_bus_arbiter
    import sram_bus_arbiter_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned STARVE_LIMIT    = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              inst_req,
    input  logic              inst_wr,
    input  logic [SIZE_W-1:0] inst_size,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic [STRB_W-1:0] inst_wstrb,
    input  logic [DATA_W-1:0] inst_wdata,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [SIZE_W-1:0] data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [STRB_W-1:0] data_wstrb,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [SIZE_W-1:0] mem_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [STRB_W-1:0] mem_wstrb,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

    arb_id_e             grant;
    arb_id_e             locked_id_q, locked_id_d;
    arb_id_e             head_id;
    logic                lock_q, lock_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                starve_hit;
    logic                granted_req;
    logic                accept;
    logic                resp;
    logic                fifo_full, fifo_empty, fifo_head;
    sram_req_t           inst_pl, data_pl, mem_pl;

    assign inst_pl = {inst_wr, inst_size, inst_addr, inst_wstrb, inst_wdata};
    assign data_pl = {data_wr, data_size, data_addr, data_wstrb, data_wdata};

    // Grant: a pending handshake keeps its master; otherwise data wins unless inst is starved.
    always_comb begin
        starve_hit = inst_req && (starve_q == STARVE_W'(STARVE_LIMIT));
        if (!resetn) begin
            grant = ID_INST;
        end else if (lock_q) begin
            grant = locked_id_q;
        end else if (data_req && !starve_hit) begin
            grant = ID_DATA;
        end else begin
            grant = ID_INST;
        end
    end

    assign granted_req = (grant == ID_DATA) ? data_req : inst_req;
    assign mem_pl      = (grant == ID_DATA) ? data_pl : inst_pl;
    assign mem_req     = resetn && granted_req && !fifo_full;
    assign mem_wr      = mem_pl.wr;
    assign mem_size    = mem_pl.size;
    assign mem_addr    = mem_pl.addr;
    assign mem_wstrb   = mem_pl.wstrb;
    assign mem_wdata   = mem_pl.wdata;

    assign accept       = mem_req && mem_addr_ok;
    assign inst_addr_ok = accept && (grant == ID_INST);
    assign data_addr_ok = accept && (grant == ID_DATA);

    // A response with nothing outstanding is dropped rather than misrouted.
    assign head_id      = arb_id_e'(fifo_head);
    assign resp         = resetn && mem_data_ok && !fifo_empty;
    assign inst_data_ok = resp && (head_id == ID_INST);
    assign data_data_ok = resp && (head_id == ID_DATA);
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .push_i  (accept),
        .din_i   (grant == ID_DATA),
        .pop_i   (resp),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

    always_comb begin
        lock_d      = lock_q;
        locked_id_d = locked_id_q;
        starve_d    = starve_q;
        if (accept) begin
            lock_d = 1'b0;
        end else if (mem_req) begin
            lock_d      = 1'b1;
            locked_id_d = grant;
        end
        // Starvation counts data accepts made while inst waits; saturates at the limit.
        if (!inst_req) begin
            starve_d = '0;
        end else if (accept && (grant == ID_INST)) begin
            starve_d = '0;
        end else if (accept && (starve_q != STARVE_W'(STARVE_LIMIT))) begin
            starve_d = starve_q + STARVE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            lock_q      <= 1'b0;
            locked_id_q <= ID_INST;
            starve_q    <= '0;
        end else begin
            lock_q      <= lock_d;
            locked_id_q <= locked_id_d;
            starve_q    <= starve_d;
        end
    end

    always_ff @(posedge clk) begin
        if (resetn && mem_data_ok) begin
            assert (!fifo_empty)
                else $error("sram_bus_arbiter: mem_data_ok with no outstanding transaction");
        end
    end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Self-checking bench for sram_bus_arbiter: directed scenarios plus randomized traffic against a queue model.
module tb_sram_bus_arbiter;

    localparam int unsigned MAXO = 2;
    localparam int unsigned SLIM = 4;
    localparam logic [31:0] A_ADDR = 32'h1c00_0000;
    localparam logic [31:0] B_ADDR = 32'h8000_1230;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req, inst_wr, inst_addr_ok, inst_data_ok;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata, inst_rdata;
    logic [3:0]  inst_wstrb;
    logic        data_req, data_wr, data_addr_ok, data_data_ok;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [3:0]  data_wstrb;
    logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // Reference model: outstanding issuer IDs (1 = data) in acceptance order.
    bit mq[$];
    bit m_lock;
    bit m_lid;
    int m_starve;

    always #5 clk = ~clk;

    sram_bus_arbiter #(.MAX_OUTSTANDING(MAXO), .STARVE_LIMIT(SLIM)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
        .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
        .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
    );

    task automatic idle_inputs();
        inst_req = 1'b0; inst_wr = 1'b0; inst_size = 2'b10; inst_addr = A_ADDR;
        inst_wstrb = 4'h0; inst_wdata = 32'h1111_1111;
        data_req = 1'b0; data_wr = 1'b1; data_size = 2'b01; data_addr = B_ADDR;
        data_wstrb = 4'h3; data_wdata = 32'h2222_2222;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'h0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        mq.delete();
        m_lock = 1'b0; m_lid = 1'b0; m_starve = 0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        idle_inputs();
        inst_req = 1'b1; data_req = 1'b1; mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk_cnt++;
        if ({mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 5'b0)
            $display("FAIL reset_ctrl: got %b expected 00000",
                     {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok});
        else pass_cnt++;
        chk_cnt++;
        if ({mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata} !== {1'b0, 2'b10, A_ADDR, 4'h0, 32'h1111_1111})
            $display("FAIL reset_payload: got addr %h wdata %h expected inst payload", mem_addr, mem_wdata);
        else pass_cnt++;
        @(negedge clk);
        resetn = 1'b1;
        idle_inputs();
        #1;
        chk_cnt++;
        if ({mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 5'b0)
            $display("FAIL reset_idle: got %b expected 00000",
                     {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok});
        else pass_cnt++;
    endtask

    task automatic test_inst_read();
        do_reset();
        inst_req = 1'b1; mem_addr_ok = 1'b1;
        #1;
        chk_cnt++;
        if ({mem_req, inst_addr_ok, data_addr_ok, mem_addr} !== {3'b110, 32'h1c00_0000})
            $display("FAIL inst_accept: got %b addr %h expected 110 addr 1c000000",
                     {mem_req, inst_addr_ok, data_addr_ok}, mem_addr);
        else pass_cnt++;
        @(negedge clk);
        inst_req = 1'b0; mem_addr_ok = 1'b0;
        #1;
        chk_cnt++;
        if ({inst_data_ok, data_data_ok, inst_addr_ok} !== 3'b000)
            $display("FAIL inst_wait: got %b expected 000", {inst_data_ok, data_data_ok, inst_addr_ok});
        else pass_cnt++;
        @(negedge clk);
        mem_data_ok = 1'b1; mem_rdata = 32'h0280_0000;
        #1;
        chk_cnt++;
        if ({inst_data_ok, data_data_ok, inst_rdata} !== {2'b10, 32'h0280_0000})
            $display("FAIL inst_resp: got %b rdata %h expected 10 rdata 02800000",
                     {inst_data_ok, data_data_ok}, inst_rdata);
        else pass_cnt++;
        @(negedge clk);
        mem_data_ok = 1'b0;
        #1;
        chk_cnt++;
        if ({inst_data_ok, data_data_ok} !== 2'b00)
            $display("FAIL inst_resp_end: got %b expected 00", {inst_data_ok, data_data_ok});
        else pass_cnt++;
    endtask

    task automatic test_priority();
        do_reset();
        inst_req = 1'b1; data_req = 1'b1; mem_addr_ok = 1'b1;
        #1;
        chk_cnt++;
        if ({inst_addr_ok, data_addr_ok, mem_addr} !== {2'b01, B_ADDR})
            $display("FAIL prio_data_first: got %b addr %h expected 01 addr %h",
                     {inst_addr_ok, data_addr_ok}, mem_addr, B_ADDR);
        else pass_cnt++;
        @(negedge clk);
        data_req = 1'b0;
        #1;
        chk_cnt++;
        if ({inst_addr_ok, data_addr_ok, mem_addr} !== {2'b10, A_ADDR})
            $display("FAIL prio_inst_next: got %b addr %h expected 10 addr %h",
                     {inst_addr_ok, data_addr_ok}, mem_addr, A_ADDR);
        else pass_cnt++;
        @(negedge clk);
        inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'hdead_0001;
        #1;
        chk_cnt++;
        if ({inst_data_ok, data_data_ok, data_rdata} !== {2'b01, 32'hdead_0001})
            $display("FAIL prio_resp_data: got %b rdata %h expected 01 rdata dead0001",
                     {inst_data_ok, data_data_ok}, data_rdata);
        else pass_cnt++;
        @(negedge clk);
        mem_rdata = 32'hbeef_0002;
        #1;
        chk_cnt++;
        if ({inst_data_ok, data_data_ok, inst_rdata} !== {2'b10, 32'hbeef_0002})
            $display("FAIL prio_resp_inst: got %b rdata %h expected 10 rdata beef0002",
                     {inst_data_ok, data_data_ok}, inst_rdata);
        else pass_cnt++;
        @(negedge clk);
        mem_data_ok = 1'b0;
    endtask

    task automatic test_lock();
        do_reset();
        data_req = 1'b1;
        #1;
        chk_cnt++;
        if ({mem_req, inst_addr_ok, data_addr_ok, mem_addr} !== {3'b100, B_ADDR})
            $display("FAIL lock_start: got %b addr %h expected 100 addr %h",
                     {mem_req, inst_addr_ok, data_addr_ok}, mem_addr, B_ADDR);
        else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            data_req = 1'b0; inst_req = 1'b1;
            #1;
            chk_cnt++;
            if ({mem_req, inst_addr_ok, data_addr_ok, mem_addr} !== {3'b000, B_ADDR})
                $display("FAIL lock_hold_data cyc%0d: got %b addr %h expected 000 addr %h",
                         i, {mem_req, inst_addr_ok, data_addr_ok}, mem_addr, B_ADDR);
            else pass_cnt++;
        end
        @(negedge clk);
        data_req = 1'b1; mem_addr_ok = 1'b1;
        #1;
        chk_cnt++;
        if ({inst_addr_ok, data_addr_ok} !== 2'b01)
            $display("FAIL lock_data_accept: got %b expected 01", {inst_addr_ok, data_addr_ok});
        else pass_cnt++;
        @(negedge clk);
        data_req = 1'b0;
        #1;
        chk_cnt++;
        if ({inst_addr_ok, data_addr_ok, mem_addr} !== {2'b10, A_ADDR})
            $display("FAIL lock_inst_after: got %b addr %h expected 10", {inst_addr_ok, data_addr_ok}, mem_addr);
        else pass_cnt++;

        do_reset();
        inst_req = 1'b1;
        @(negedge clk);
        data_req = 1'b1; mem_addr_ok = 1'b1;
        #1;
        chk_cnt++;
        if ({inst_addr_ok, data_addr_ok, mem_addr} !== {2'b10, A_ADDR})
            $display("FAIL lock_hold_inst: got %b addr %h expected 10 addr %h",
                     {inst_addr_ok, data_addr_ok}, mem_addr, A_ADDR);
        else pass_cnt++;
        @(negedge clk);
        inst_req = 1'b0; data_req = 1'b0; mem_addr_ok = 1'b0;
    endtask

    task automatic test_full();
        do_reset();
        inst_req = 1'b1; mem_addr_ok = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk_cnt++;
            if ({mem_req, inst_addr_ok} !== 2'b11)
                $display("FAIL full_fill%0d: got %b expected 11", i, {mem_req, inst_addr_ok});
            else pass_cnt++;
            @(negedge clk);
        end
        #1;
        chk_cnt++;
        if ({mem_req, inst_addr_ok} !== 2'b00)
            $display("FAIL full_block: got %b expected 00", {mem_req, inst_addr_ok});
        else pass_cnt++;
        @(negedge clk);
        mem_data_ok = 1'b1;
        #1;
        chk_cnt++;
        if ({mem_req, inst_addr_ok, inst_data_ok} !== 3'b001)
            $display("FAIL full_no_bypass: got %b expected 001", {mem_req, inst_addr_ok, inst_data_ok});
        else pass_cnt++;
        @(negedge clk);
        mem_data_ok = 1'b0;
        #1;
        chk_cnt++;
        if ({mem_req, inst_addr_ok} !== 2'b11)
            $display("FAIL full_reassert: got %b expected 11", {mem_req, inst_addr_ok});
        else pass_cnt++;
        @(negedge clk);
        inst_req = 1'b0; mem_addr_ok = 1'b0;
    endtask

    task automatic test_starvation();
        int occ;
        logic [1:0] exp_ok;
        do_reset();
        occ = 0;
        inst_req = 1'b1; data_req = 1'b1; mem_addr_ok = 1'b1;
        for (int k = 0; k < 20; k++) begin
            mem_data_ok = (occ > 0);
            #1;
            exp_ok = (k % 5 == 4) ? 2'b10 : 2'b01;
            chk_cnt++;
            if ({inst_addr_ok, data_addr_ok} !== exp_ok)
                $display("FAIL starve_pattern grant%0d: got %b expected %b", k, {inst_addr_ok, data_addr_ok}, exp_ok);
            else pass_cnt++;
            occ = occ + 1 - (mem_data_ok ? 1 : 0);
            @(negedge clk);
        end
        inst_req = 1'b0; data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        inst_req = 1'b1; mem_addr_ok = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk_cnt++;
        if (mem_req !== 1'b0)
            $display("FAIL rstmid_full: got mem_req %b expected 0", mem_req);
        else pass_cnt++;
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        #1;
        chk_cnt++;
        if ({mem_req, inst_addr_ok} !== 2'b11)
            $display("FAIL rstmid_cleared: got %b expected 11", {mem_req, inst_addr_ok});
        else pass_cnt++;
        @(negedge clk);
        inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
        #1;
        chk_cnt++;
        if ({inst_data_ok, data_data_ok} !== 2'b10)
            $display("FAIL rstmid_resp: got %b expected 10", {inst_data_ok, data_data_ok});
        else pass_cnt++;
        @(negedge clk);
        mem_data_ok = 1'b0;
    endtask

    task automatic test_random();
        bit e_grant, e_mreq, e_acc, e_rsp, e_head;
        logic [4:0]  e_ctl, g_ctl;
        logic [70:0] e_pl, g_pl;
        logic [31:0] g_rd;
        int errs;
        do_reset();
        errs = 0;
        for (int c = 0; c < 400; c++) begin
            inst_req    = ($urandom_range(0, 3) != 0);
            data_req    = ($urandom_range(0, 3) != 0);
            inst_wr     = 1'($urandom_range(0, 1));
            data_wr     = 1'($urandom_range(0, 1));
            inst_size   = 2'($urandom_range(0, 3));
            data_size   = 2'($urandom_range(0, 3));
            inst_addr   = $urandom;
            data_addr   = $urandom;
            inst_wstrb  = 4'($urandom_range(0, 15));
            data_wstrb  = 4'($urandom_range(0, 15));
            inst_wdata  = $urandom;
            data_wdata  = $urandom;
            mem_addr_ok = ($urandom_range(0, 2) != 0);
            mem_data_ok = (mq.size() > 0) && ($urandom_range(0, 2) != 0);
            mem_rdata   = $urandom;
            #1;
            e_grant = m_lock ? m_lid : (data_req && !(inst_req && m_starve == SLIM));
            e_mreq  = (e_grant ? data_req : inst_req) && (mq.size() < MAXO);
            e_acc   = e_mreq && mem_addr_ok;
            e_rsp   = mem_data_ok && (mq.size() > 0);
            e_head  = (mq.size() > 0) ? mq[0] : 1'b0;
            e_ctl   = {e_mreq, e_acc && !e_grant, e_acc && e_grant, e_rsp && !e_head, e_rsp && e_head};
            g_ctl   = {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok};
            chk_cnt++;
            if (g_ctl !== e_ctl) begin
                errs++;
                if (errs <= 10)
                    $display("FAIL rand_ctl cyc%0d: got %b expected %b", c, g_ctl, e_ctl);
            end else pass_cnt++;
            e_pl = e_grant ? {data_wr, data_size, data_addr, data_wstrb, data_wdata}
                           : {inst_wr, inst_size, inst_addr, inst_wstrb, inst_wdata};
            g_pl = {mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata};
            chk_cnt++;
            if (g_pl !== e_pl) begin
                errs++;
                if (errs <= 10)
                    $display("FAIL rand_payload cyc%0d: got %h expected %h", c, g_pl, e_pl);
            end else pass_cnt++;
            if (e_rsp) begin
                g_rd = e_head ? data_rdata : inst_rdata;
                chk_cnt++;
                if (g_rd !== mem_rdata) begin
                    errs++;
                    if (errs <= 10)
                        $display("FAIL rand_rdata cyc%0d: got %h expected %h", c, g_rd, mem_rdata);
                end else pass_cnt++;
            end
            if (e_rsp) void'(mq.pop_front());
            if (e_acc) mq.push_back(e_grant);
            if (e_acc) m_lock = 1'b0;
            else if (e_mreq) begin
                m_lock = 1'b1;
                m_lid  = e_grant;
            end
            if (!inst_req) m_starve = 0;
            else if (e_acc && !e_grant) m_starve = 0;
            else if (e_acc && e_grant && m_starve < SLIM) m_starve++;
            @(negedge clk);
        end
        idle_inputs();
    endtask

    initial begin
        resetn = 1'b0;
        idle_inputs();
        test_reset();
        test_inst_read();
        test_priority();
        test_lock();
        test_full();
        test_starvation();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
